// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//   UART transmitter that drains the read side of a FIFO running on the same
//   clock. Each word becomes one frame on the line: a start bit, the data bits
//   LSB first, an optional parity bit, then the stop bits.
//
// Ports
//   clk_i         clock (same clock as the FIFO read side)
//   rstn_i        asynchronous active-low reset
//   enable_i      allows a new frame to start
//   baud_div_i    clock cycles per bit; a value of 0 is treated as 1
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO read data, valid in the cycle after a pop
//   fifo_pop_o    FIFO read enable
//   tx_o          serial line, idle high
//   busy_o        high while a frame is in progress (state != IDLE)
//   frame_done_o  one-cycle pulse after the last stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY     = 0,   // 0 none, 1 even, 2 odd
    parameter int STOP_BITS  = 1    // 1 or 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int CW = DIV_WIDTH + 1;          // one spare bit holds 2*div for two stop bits
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  par_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bitcnt_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DIV_WIDTH-1:0]  div_d;
    logic [CW-1:0]         bit_len_m1;
    logic [CW-1:0]         stop_len_m1;
    logic                  pop;

    assign div_d       = (baud_div_i == '0) ? DIV_WIDTH'(1) : baud_div_i;
    assign bit_len_m1  = {1'b0, div_q} - CW'(1);
    assign stop_len_m1 = (STOP_BITS == 2) ? ({div_q, 1'b0} - CW'(1)) : bit_len_m1;

    // Gated by rstn_i so no pop can escape while reset is held.
    assign pop = rstn_i & (state_q == S_IDLE) & enable_i & ~fifo_empty_i;

    assign fifo_pop_o   = pop;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                // Read data is valid now; latch the word and the divisor for
                // the whole frame so later input changes cannot disturb it.
                S_FETCH: begin
                    shreg_q <= fifo_data_i;
                    par_q   <= (^fifo_data_i) ^ (PARITY == 2);
                    div_q   <= div_d;
                    cnt_q   <= {1'b0, div_d} - CW'(1);
                    tx_q    <= 1'b0;
                    state_q <= S_START;
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_DATA;
                        tx_q     <= shreg_q[0];
                        cnt_q    <= bit_len_m1;
                        bitcnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shreg_q <= shreg_q >> 1;
                        if (bitcnt_q == BW'(DATA_WIDTH - 1)) begin
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_q;
                                cnt_q   <= bit_len_m1;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                                cnt_q   <= stop_len_m1;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + BW'(1);
                            tx_q     <= shreg_q[1];  // next bit, before the shift lands
                            cnt_q    <= bit_len_m1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        cnt_q   <= stop_len_m1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Three transmitters share one FIFO model: dut 0 has no parity and one stop
//   bit, dut 1 has even parity and two stop bits, dut 2 has odd parity and one
//   stop bit. Only the selected dut sees a non-empty FIFO.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  en;
    logic [15:0] baud;
    logic [2:0]  emp, pop, tx, busy, done;
    logic [7:0]  rdata;
    int          sel;

    // FIFO model: pointers have a single writer each
    logic [7:0]  mem [0:63];
    int          wr = 0;
    int          rd = 0;

    int checks = 0;
    int errs   = 0;
    int cyc = 0, last_pop = 0, npop = 0, ndone = 0, dbl = 0;
    logic [2:0] prev_pop = '0;

    always #5 clk = ~clk;

    assign emp[0] = !(sel == 0 && wr != rd);
    assign emp[1] = !(sel == 1 && wr != rd);
    assign emp[2] = !(sel == 2 && wr != rd);

    fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en[0]), .baud_div_i(baud),
        .fifo_empty_i(emp[0]), .fifo_data_i(rdata), .fifo_pop_o(pop[0]),
        .tx_o(tx[0]), .busy_o(busy[0]), .frame_done_o(done[0]));
    fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY(1), .STOP_BITS(2)) u1 (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en[1]), .baud_div_i(baud),
        .fifo_empty_i(emp[1]), .fifo_data_i(rdata), .fifo_pop_o(pop[1]),
        .tx_o(tx[1]), .busy_o(busy[1]), .frame_done_o(done[1]));
    fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en[2]), .baud_div_i(baud),
        .fifo_empty_i(emp[2]), .fifo_data_i(rdata), .fifo_pop_o(pop[2]),
        .tx_o(tx[2]), .busy_o(busy[2]), .frame_done_o(done[2]));

    always @(posedge clk) begin
        if (pop[sel]) begin
            rdata <= mem[rd[5:0]];
            rd    <= rd + 1;
        end
    end

    // Monitor: cycle count, pop/done counts, back-to-back pop detection
    always @(posedge clk) begin
        if (|pop) begin
            last_pop = cyc;
            npop     = npop + 1;
        end
        if ((pop & prev_pop) != '0) dbl = dbl + 1;
        prev_pop = pop;
        if (|done) ndone = ndone + 1;
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr[5:0]] = d;
        wr = wr + 1;
    endtask

    function automatic logic txs();
        return tx[sel];
    endfunction

    // Wait for a start bit, then sample nbits bits of div cycles each at negedges.
    task automatic rx_frame(input int div, input int nbits, output logic [15:0] bits,
                            output int gl, output int sc, output int ec, output bit to);
        int n = 0;
        bits = '0; gl = 0; sc = 0; ec = 0; to = 0;
        @(negedge clk);
        while (txs() !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            to = 1;
            return;
        end
        sc = cyc;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < div; j++) begin
                if (i != 0 || j != 0) @(negedge clk);
                if (j == 0) bits[i] = txs();
                else if (txs() !== bits[i]) gl++;
            end
        end
        ec = cyc;
    endtask

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [15:0] baud;
        int          bdiv;
        int          nbits;
        logic [15:0] exp;   // line bits in time order, bit 0 = start bit
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [15:0] bits, mask;
        int gl, sc, ec, p0, d0, lows, bz, prev_ec;
        bit to;

        vt[0] = '{0, 8'hA5, 16'd4, 4, 10, {6'b0, 1'b1, 8'hA5, 1'b0}};
        vt[1] = '{0, 8'h3C, 16'd0, 1, 10, {6'b0, 1'b1, 8'h3C, 1'b0}};
        vt[2] = '{0, 8'hFF, 16'd1, 1, 10, {6'b0, 1'b1, 8'hFF, 1'b0}};
        vt[3] = '{0, 8'h00, 16'd7, 7, 10, {6'b0, 1'b1, 8'h00, 1'b0}};
        vt[4] = '{1, 8'h07, 16'd2, 2, 12, {4'b0, 2'b11, 1'b1, 8'h07, 1'b0}};
        vt[5] = '{1, 8'h03, 16'd2, 2, 12, {4'b0, 2'b11, 1'b0, 8'h03, 1'b0}};
        vt[6] = '{2, 8'h07, 16'd2, 2, 11, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
        vt[7] = '{2, 8'h00, 16'd3, 3, 11, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}};

        // Reset state, then idle with an empty FIFO
        sel = 0; en = 3'b111; baud = 16'd4; rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 3'b111);
        chk("rst_busy", busy, 3'b000);
        chk("rst_pop", pop, 3'b000);
        chk("rst_done", done, 3'b000);
        rstn = 1'b1;
        lows = 0; bz = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx != 3'b111) lows++;
            if (busy != 3'b000) bz++;
        end
        chk("idle_tx_low", lows, 0);
        chk("idle_busy", bz, 0);
        chk("idle_pops", npop, 0);

        // Single frames from the vector table
        for (int v = 0; v < 8; v++) begin
            sel = vt[v].sel; en = 3'b001 << sel; baud = vt[v].baud;
            p0 = npop; d0 = ndone;
            mask = (16'h1 << vt[v].nbits) - 16'h1;
            push(vt[v].data);
            rx_frame(vt[v].bdiv, vt[v].nbits, bits, gl, sc, ec, to);
            chk($sformatf("v%0d_timeout", v), 32'(to), 0);
            chk($sformatf("v%0d_bits", v), bits & mask, vt[v].exp);
            chk($sformatf("v%0d_bitlen", v), gl, 0);
            chk($sformatf("v%0d_latency", v), sc - last_pop, 2);
            @(negedge clk);
            chk($sformatf("v%0d_done", v), 32'(done[sel]), 1);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_pops", v), npop - p0, 1);
            chk($sformatf("v%0d_dones", v), ndone - d0, 1);
            chk($sformatf("v%0d_busy", v), 32'(busy[sel]), 0);
        end

        // Back-to-back frames: exactly 2 idle-high cycles between frames
        sel = 0; en = 3'b000; baud = 16'd3; p0 = npop;
        push(8'h55); push(8'hAA); push(8'h0F);
        @(negedge clk);
        en = 3'b001;
        prev_ec = 0;
        for (int f = 0; f < 3; f++) begin
            logic [7:0] d;
            d = (f == 0) ? 8'h55 : (f == 1) ? 8'hAA : 8'h0F;
            rx_frame(3, 10, bits, gl, sc, ec, to);
            chk($sformatf("b2b%0d_timeout", f), 32'(to), 0);
            chk($sformatf("b2b%0d_bits", f), bits & 16'h3FF, {6'b0, 1'b1, d, 1'b0});
            chk($sformatf("b2b%0d_bitlen", f), gl, 0);
            if (f != 0) chk($sformatf("b2b%0d_gap", f), sc - prev_ec, 3);
            prev_ec = ec;
        end
        repeat (4) @(negedge clk);
        chk("b2b_pops", npop - p0, 3);

        // Divisor change mid-frame affects only the next frame
        baud = 16'd4;
        push(8'h12); push(8'h34);
        fork
            rx_frame(4, 10, bits, gl, sc, ec, to);
            begin
                repeat (10) @(posedge clk);
                baud = 16'd8;
            end
        join
        chk("bchg0_bits", bits & 16'h3FF, {6'b0, 1'b1, 8'h12, 1'b0});
        chk("bchg0_bitlen", gl + 32'(to), 0);
        rx_frame(8, 10, bits, gl, sc, ec, to);
        chk("bchg1_bits", bits & 16'h3FF, {6'b0, 1'b1, 8'h34, 1'b0});
        chk("bchg1_bitlen", gl + 32'(to), 0);
        repeat (4) @(negedge clk);

        // Reset during data bit 3, then the next word goes out cleanly
        baud = 16'd4;
        push(8'h5A); push(8'hC3);
        lows = 0;
        @(negedge clk);
        while (txs() !== 1'b0 && lows < 400) begin
            @(negedge clk);
            lows++;
        end
        chk("rstmid_start", 32'(lows < 400), 1);
        repeat (16) @(negedge clk);     // start bit + data bits 0..2
        chk("rstmid_bit3", 32'(txs()), 32'(1'b1));  // bit 3 of 0x5A
        #1 rstn = 1'b0;
        #1;
        chk("rstmid_tx", 32'(tx[0]), 1);
        chk("rstmid_busy", 32'(busy[0]), 0);
        chk("rstmid_pop", 32'(pop[0]), 0);
        @(negedge clk);
        rstn = 1'b1;
        rx_frame(4, 10, bits, gl, sc, ec, to);
        chk("rstmid_next_bits", bits & 16'h3FF, {6'b0, 1'b1, 8'hC3, 1'b0});
        chk("rstmid_next_bitlen", gl + 32'(to), 0);
        repeat (4) @(negedge clk);

        chk("no_double_pop", dbl, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
